obi_wb_bridge_arbiter: RTL and testbench

- Connects N OBI-style (req/gnt/rvalid) master ports to one Wishbone classic master port.
- Typical use: core instruction and data ports feeding the Controller core bus (cyc/stb/we/addr/data/ack).
- Successor to single-port, hard-wired core hookups. Adds parametrised port count, widths and arbitration mode, plus error propagation.
- Exactly one Wishbone transaction is in flight at any time. Each port may have at most one outstanding request.

---
 rtl/obi_wb_pkg.sv | 26 ++
 rtl/obi_wb_bridge_arbiter_rr_arbiter.sv | 48 ++++
 rtl/obi_wb_bridge_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_obi_wb_bridge_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI-to-Wishbone bridge/arbiter.
//   state_t   : bridge FSM states (IDLE, BUS, RESP)
//   ARB_FIXED : fixed-priority arbitration (port 0 highest)
//   ARB_RR    : round-robin arbitration
//   be_width  : byte-enable width for a given data width
//   idx_width : width of a port index (minimum 1 bit)
package obi_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  function automatic int unsigned be_width(input int unsigned dw);
    return dw / 8;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_wb_bridge_arbiter_rr_arbiter.sv
// Combinational port arbiter for the OBI-to-Wishbone bridge.
//   req  : per-port request vector
//   ptr  : round-robin start position (ignored in fixed-priority mode)
//   gnt  : one-hot grant (all zero when nothing requests)
//   idx  : index of the winning port (0 when nothing requests)
// MODE = ARB_RR    : first requester at or above ptr, wrapping around.
// MODE = ARB_FIXED : lowest-index requester.
module rr_arbiter
  import obi_wb_pkg::*;
#(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned MODE    = ARB_RR
) (
  input  logic [N_PORTS-1:0]              req,
  input  logic [idx_width(N_PORTS)-1:0]   ptr,
  output logic [N_PORTS-1:0]              gnt,
  output logic [idx_width(N_PORTS)-1:0]   idx
);

  localparam int unsigned IDX_W = idx_width(N_PORTS);

  int unsigned off;
  int unsigned cand;

  // Candidates are scanned from the farthest offset down to offset 0, so the
  // last match written (nearest to the start position) is the winner.
  always_comb begin
    idx  = '0;
    off  = 0;
    cand = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      off  = N_PORTS - 1 - k;
      cand = (MODE == ARB_RR) ? 32'(ptr) + off : off;
      if (cand >= N_PORTS) cand = cand - N_PORTS;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (p == cand && req[p]) idx = IDX_W'(p);
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      gnt[p] = (|req) && (idx == IDX_W'(p));
    end
  end

endmodule

// File: rtl/obi_wb_bridge_arbiter.sv
// Bridges N OBI-style (req/gnt/rvalid) master ports onto one Wishbone classic
// master port, one transaction in flight at a time.
// Optional feature: define OBI_WB_BRIDGE_TIMEOUT_EN to end a Wishbone cycle
// with an error after TIMEOUT_CYCLES bus cycles without ack/err.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   obi_req_i / obi_gnt_o         : per-port request / combinational grant
//   obi_we_i, obi_be_i            : per-port write enable / byte enables
//   obi_addr_i, obi_wdata_i       : per-port address / write data (port 0 in LSBs)
//   obi_rvalid_o                  : per-port one-cycle response valid
//   obi_rdata_o, obi_err_o        : shared response data / error
//   wb_cyc_o, wb_stb_o, wb_we_o   : Wishbone cycle, strobe, write enable
//   wb_sel_o, wb_addr_o, wb_data_o: Wishbone byte select, address, write data
//   wb_data_i, wb_ack_i, wb_err_i : Wishbone read data, acknowledge, error
module obi_wb_bridge_arbiter
  import obi_wb_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ARB_MODE       = ARB_RR,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_PORTS-1:0]                   obi_req_i,
  output logic [N_PORTS-1:0]                   obi_gnt_o,
  input  logic [N_PORTS-1:0]                   obi_we_i,
  input  logic [N_PORTS*be_width(DATA_WIDTH)-1:0] obi_be_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]        obi_addr_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]        obi_wdata_i,
  output logic [N_PORTS-1:0]                   obi_rvalid_o,
  output logic [DATA_WIDTH-1:0]                obi_rdata_o,
  output logic                                 obi_err_o,
  output logic                                 wb_cyc_o,
  output logic                                 wb_stb_o,
  output logic                                 wb_we_o,
  output logic [be_width(DATA_WIDTH)-1:0]      wb_sel_o,
  output logic [ADDR_WIDTH-1:0]                wb_addr_o,
  output logic [DATA_WIDTH-1:0]                wb_data_o,
  input  logic [DATA_WIDTH-1:0]                wb_data_i,
  input  logic                                 wb_ack_i,
  input  logic                                 wb_err_i
);

  localparam int unsigned BE_W  = be_width(DATA_WIDTH);
  localparam int unsigned IDX_W = idx_width(N_PORTS);

  if (N_PORTS < 1 || N_PORTS > 8 || (DATA_WIDTH % 8) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("obi_wb_bridge_arbiter: invalid parameter configuration");
  end

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, win_q, arb_idx;
  logic [N_PORTS-1:0]      arb_gnt;
  logic                    we_q, err_q;
  logic [BE_W-1:0]         be_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic                    sel_we;
  logic [BE_W-1:0]         sel_be;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    to_hit;
  logic                    in_bus, in_resp;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .MODE    (ARB_MODE)
  ) u_arb (
    .req (obi_req_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Request fields of the current arbitration winner.
  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (arb_idx == IDX_W'(p)) begin
        sel_we    = obi_we_i[p];
        sel_be    = obi_be_i[p*BE_W +: BE_W];
        sel_addr  = obi_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = obi_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  // Holds zero outside BUS, so it starts from zero on every BUS entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 to_cnt_q <= '0;
    else if (state_q != BUS) to_cnt_q <= '0;
    else                     to_cnt_q <= to_cnt_q + 16'd1;
  end

  // Count value TIMEOUT_CYCLES-1 marks the last permitted BUS cycle.
  assign to_hit = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|obi_req_i) state_d = BUS;
      BUS:     if (wb_ack_i || wb_err_i || to_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|obi_req_i) begin
            win_q   <= arb_idx;
            we_q    <= sel_we;
            be_q    <= sel_be;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
          end
        end
        BUS: begin
          // A real ack/err in the final counted cycle beats the timeout.
          if (wb_ack_i || wb_err_i) begin
            err_q   <= wb_err_i;
            rdata_q <= we_q ? '0 : wb_data_i;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        RESP: begin
          if (ARB_MODE == ARB_RR) begin
            ptr_q <= (win_q == IDX_W'(N_PORTS - 1)) ? '0 : win_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_bus  = (state_q == BUS);
  assign in_resp = (state_q == RESP);

  // Grant is combinational from the requests; rst gating keeps it low while
  // reset is held even though the FSM already sits in IDLE.
  assign obi_gnt_o = (state_q == IDLE && !rst) ? arb_gnt : '0;

  always_comb begin
    obi_rvalid_o = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      obi_rvalid_o[p] = in_resp && (win_q == IDX_W'(p));
    end
  end

  assign obi_rdata_o = rdata_q;
  assign obi_err_o   = in_resp & err_q;

  assign wb_cyc_o  = in_bus;
  assign wb_stb_o  = in_bus;
  assign wb_we_o   = in_bus & we_q;
  assign wb_sel_o  = in_bus ? be_q    : '0;
  assign wb_addr_o = in_bus ? addr_q  : '0;
  assign wb_data_o = in_bus ? wdata_q : '0;

endmodule

// File: tb/tb_obi_wb_bridge_arbiter.sv
// Directed self-checking bench for obi_wb_bridge_arbiter.
// u_dut is round-robin (TIMEOUT_CYCLES=8); u_fix is a fixed-priority copy
// sharing the OBI inputs, with its Wishbone ack tied to its own strobe.
module tb_obi_wb_bridge_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req, we;
  logic [NP*BW-1:0] be;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;

  logic [NP-1:0] gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          err;
  logic          cyc, stb, wbwe;
  logic [BW-1:0] sel;
  logic [AW-1:0] wadr;
  logic [DW-1:0] wdo, wdi;
  logic          ack, werr, auto_ack, ack_drv;

  logic [NP-1:0] f_gnt, f_rvalid;
  logic [DW-1:0] f_rdata, f_dat;
  logic          f_err, f_cyc, f_stb, f_we;
  logic [BW-1:0] f_sel;
  logic [AW-1:0] f_adr;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  assign ack = auto_ack ? stb : ack_drv;

  always #5 clk = ~clk;

  obi_wb_bridge_arbiter #(
    .N_PORTS        (NP),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .ARB_MODE       (1),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .obi_req_i    (req),
    .obi_gnt_o    (gnt),
    .obi_we_i     (we),
    .obi_be_i     (be),
    .obi_addr_i   (addr),
    .obi_wdata_i  (wdata),
    .obi_rvalid_o (rvalid),
    .obi_rdata_o  (rdata),
    .obi_err_o    (err),
    .wb_cyc_o     (cyc),
    .wb_stb_o     (stb),
    .wb_we_o      (wbwe),
    .wb_sel_o     (sel),
    .wb_addr_o    (wadr),
    .wb_data_o    (wdo),
    .wb_data_i    (wdi),
    .wb_ack_i     (ack),
    .wb_err_i     (werr)
  );

  obi_wb_bridge_arbiter #(
    .N_PORTS        (NP),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .ARB_MODE       (0),
    .TIMEOUT_CYCLES (8)
  ) u_fix (
    .clk          (clk),
    .rst          (rst),
    .obi_req_i    (req),
    .obi_gnt_o    (f_gnt),
    .obi_we_i     (we),
    .obi_be_i     (be),
    .obi_addr_i   (addr),
    .obi_wdata_i  (wdata),
    .obi_rvalid_o (f_rvalid),
    .obi_rdata_o  (f_rdata),
    .obi_err_o    (f_err),
    .wb_cyc_o     (f_cyc),
    .wb_stb_o     (f_stb),
    .wb_we_o      (f_we),
    .wb_sel_o     (f_sel),
    .wb_addr_o    (f_adr),
    .wb_data_o    (f_dat),
    .wb_data_i    (wdi),
    .wb_ack_i     (f_stb),
    .wb_err_i     (1'b0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction for a single requesting port, starting in IDLE.
  task automatic run_txn(input string tag, input int unsigned port, input logic w,
                         input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                         input int unsigned waits, input logic [31:0] bus_rdata,
                         input logic bus_err, input logic [31:0] exp_rdata,
                         input logic exp_err);
    logic [NP-1:0] onehot;
    onehot = '0;
    onehot[port] = 1'b1;
    we[port]             = w;
    be[port*BW +: BW]    = b;
    addr[port*AW +: AW]  = a;
    wdata[port*DW +: DW] = d;
    req = onehot;
    #1;
    check_eq({tag, "_gnt"}, 32'(gnt), 32'(onehot));
    step();
    req = '0;
    check_eq({tag, "_cyc"}, 32'({cyc, stb}), 32'h3);
    check_eq({tag, "_we"}, 32'(wbwe), 32'(w));
    check_eq({tag, "_sel"}, 32'(sel), 32'(b));
    check_eq({tag, "_addr"}, wadr, a);
    check_eq({tag, "_wdata"}, wdo, d);
    for (int unsigned i = 0; i < waits; i++) begin
      step();
      check_eq({tag, "_cyc_wait"}, 32'(cyc), 32'h1);
      check_eq({tag, "_rvalid_wait"}, 32'(rvalid), 32'h0);
    end
    wdi     = bus_rdata;
    ack_drv = 1'b1;
    werr    = bus_err;
    step();
    ack_drv = 1'b0;
    werr    = 1'b0;
    check_eq({tag, "_rvalid"}, 32'(rvalid), 32'(onehot));
    check_eq({tag, "_rdata"}, rdata, exp_rdata);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
    check_eq({tag, "_cyc_low"}, 32'(cyc), 32'h0);
    step();
    check_eq({tag, "_rvalid_once"}, 32'(rvalid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NP-1:0] rr_log [8];
    logic [NP-1:0] fx_log [8];
    int unsigned   rr_n, fx_n, n_bus;
    logic          seen;

    rst = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    wdi = '0; werr = 1'b0; auto_ack = 1'b0; ack_drv = 1'b0;
    rr_n = 0; fx_n = 0; n_bus = 0; seen = 1'b0;
    step();
    step();

    // Reset state, with requests present to show the grant is held off.
    req = 2'b11;
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_cyc", 32'({cyc, stb, wbwe}), 32'h0);
    check_eq("rst_rvalid", 32'(rvalid), 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_sel", 32'(sel), 32'h0);
    req = '0;
    rst = 1'b0;
    step();

    // Round-robin vs fixed priority, both ports requesting for 18 cycles.
    wdi = 32'h1111_2222;
    auto_ack = 1'b1;
    req = 2'b11;
    for (int unsigned c = 0; c < 18; c++) begin
      #1;
      if (gnt != '0 && rr_n < 8) begin rr_log[rr_n] = gnt; rr_n++; end
      if (f_gnt != '0 && fx_n < 8) begin fx_log[fx_n] = f_gnt; fx_n++; end
      step();
    end
    req = '0;
    auto_ack = 1'b0;
    check_eq("rr_count", rr_n, 6);
    check_eq("fix_count", fx_n, 6);
    for (int unsigned i = 0; i < 6; i++) begin
      if (i < rr_n) check_eq("rr_order", 32'(rr_log[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i < fx_n) check_eq("fix_order", 32'(fx_log[i]), 32'h1);
    end
    step();

    run_txn("rd", 1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
            32'hDEAD_BEEF, 1'b0);
    run_txn("wr", 0, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00, 0, 32'h1234_5678, 1'b0,
            32'h0, 1'b0);

    // Stray ack while idle must produce nothing.
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    check_eq("stray_rvalid", 32'(rvalid), 32'h0);
    check_eq("stray_cyc", 32'(cyc), 32'h0);
    step();
    check_eq("stray_rvalid2", 32'(rvalid), 32'h0);

    run_txn("wait", 0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 5, 32'hCAFE_0001, 1'b0,
            32'hCAFE_0001, 1'b0);
    run_txn("err", 1, 1'b0, 4'hF, 32'h0000_0204, 32'h0, 0, 32'h5555_AAAA, 1'b1,
            32'h5555_AAAA, 1'b1);
    // Port 0 served last, so the pointer now sits at 1.
    run_txn("pre", 0, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 0, 32'h0000_0033, 1'b0,
            32'h0000_0033, 1'b0);

    // Reset in the middle of a BUS cycle.
    req = 2'b10;
    #1;
    check_eq("mr_gnt", 32'(gnt), 32'h2);
    step();
    req = '0;
    check_eq("mr_cyc_bus", 32'(cyc), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mr_cyc_drop", 32'({cyc, stb}), 32'h0);
    check_eq("mr_rvalid", 32'(rvalid), 32'h0);
    step();
    check_eq("mr_rvalid2", 32'(rvalid), 32'h0);
    step();
    rst = 1'b0;
    check_eq("mr_rvalid3", 32'(rvalid), 32'h0);
    req = 2'b11;
    #1;
    check_eq("mr_ptr_gnt", 32'(gnt), 32'h1);
    wdi = 32'h0BAD_F00D;
    step();
    req = '0;
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    check_eq("mr_post_rvalid", 32'(rvalid), 32'h1);
    check_eq("mr_post_rdata", rdata, 32'h0BAD_F00D);
    step();

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
    wdi = 32'h7777_7777;
    req = 2'b01;
    #1;
    check_eq("to_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (!seen) begin
        if (rvalid != '0) begin
          seen = 1'b1;
          check_eq("to_rvalid", 32'(rvalid), 32'h1);
          check_eq("to_err", 32'(err), 32'h1);
          check_eq("to_rdata", rdata, 32'h0);
          check_eq("to_cyc_low", 32'(cyc), 32'h0);
        end else begin
          if (cyc) n_bus++;
          step();
        end
      end
    end
    check_eq("to_seen", 32'(seen), 32'h1);
    check_eq("to_bus_cycles", n_bus, 8);
    step();
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    check_eq("to_late_ack_rvalid", 32'(rvalid), 32'h0);
    check_eq("to_late_ack_cyc", 32'(cyc), 32'h0);
    step();
    check_eq("to_late_ack_rvalid2", 32'(rvalid), 32'h0);
`else
    req = 2'b01;
    #1;
    check_eq("nto_gnt", 32'(gnt), 32'h1);
    step();
    req = '0;
    repeat (20) step();
    check_eq("nto_cyc_held", 32'(cyc), 32'h1);
    check_eq("nto_rvalid", 32'(rvalid), 32'h0);
    wdi = 32'h0000_4242;
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    check_eq("nto_rvalid_end", 32'(rvalid), 32'h1);
    check_eq("nto_rdata", rdata, 32'h0000_4242);
    step();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
